serial_to_parallel_rx: RTL and testbench

Serial-to-parallel receiver that rebuilds WIDTH-bit words from a serial bit stream, shifted LSB-first by default. It is the receiving end of the team's 6-bit parallel-to-serial link. A sync pulse marks bit 0 of each frame, and a bit-enable allows the stream to stall. Each completed word is held in an output register with a valid/acknowledge handshake, and an overrun is flagged if a word is lost.

---
 rtl/serial_to_parallel_rx.sv | 138 +++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//   Rebuilds WIDTH-bit words from a serial bit stream. A sync bit marks bit 0
//   of each frame, and bit_en lets the stream stall for any number of cycles.
//   Each completed word is held in data_out behind a valid/rd_ack handshake.
//   A word that overwrites an unconsumed one sets the sticky overrun flag.
//
// Ports
//   clk        rising-edge clock
//   clear      asynchronous, active-high reset
//   serial_in  serial data bit
//   bit_en     serial_in carries a valid bit this cycle
//   sync       together with bit_en, marks bit 0 of a new frame
//   rd_ack     consumer takes data_out this cycle
//   data_out   last completed word
//   valid      data_out holds a word that has not been consumed
//   overrun    sticky: a completed word replaced an unconsumed one
//   frame_err  one-cycle pulse: a sync arrived mid-frame and aborted it
//   busy       a frame is being received (state SHIFT)
module serial_to_parallel_rx #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             bit_en,
    input  logic             sync,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             complete;

    // Register position of the k-th sampled bit.
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] k);
        return MSB_FIRST ? (LAST - k) : k;
    endfunction

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;

        if (rd_ack && valid_q) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-sync bits outside a frame are dropped.
                if (bit_en && sync) begin
                    shreg_d                 = '0;
                    shreg_d[bit_pos('0)]    = serial_in;
                    cnt_d                   = CW'(1);
                    state_d                 = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en && sync) begin
                    // Premature sync: drop the partial word, restart the frame.
                    shreg_d                 = '0;
                    shreg_d[bit_pos('0)]    = serial_in;
                    cnt_d                   = CW'(1);
                    frame_err_d             = 1'b1;
                end else if (bit_en) begin
                    shreg_d[bit_pos(cnt_q)] = serial_in;
                    if (cnt_q == LAST) begin
                        // Last bit goes straight into data_out this edge.
                        data_d   = shreg_d;
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An ack on the completion edge consumes the old word, so no overrun.
        if (complete) begin
            if (valid_q && !rd_ack) overrun_d = 1'b1;
            valid_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        data_out  = data_q;
        valid     = valid_q;
        overrun   = overrun_q;
        frame_err = frame_err_q;
        busy      = (state_q == SHIFT);
    end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: an LSB-first and an MSB-first
// instance share the same stimulus; expected values are hand-computed.
module tb_serial_to_parallel_rx;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       serial_in = 1'b0;
    logic       bit_en = 1'b0;
    logic       sync = 1'b0;
    logic       rd_ack = 1'b0;
    logic [5:0] data_out, data_m;
    logic       valid, overrun, frame_err, busy;
    logic       valid_m, overrun_m, frame_err_m, busy_m;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_to_parallel_rx #(.WIDTH(6), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .clear(clear), .serial_in(serial_in), .bit_en(bit_en),
        .sync(sync), .rd_ack(rd_ack), .data_out(data_out), .valid(valid),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    serial_to_parallel_rx #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clear(clear), .serial_in(serial_in), .bit_en(bit_en),
        .sync(sync), .rd_ack(rd_ack), .data_out(data_m), .valid(valid_m),
        .overrun(overrun_m), .frame_err(frame_err_m), .busy(busy_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic en, input logic s, input logic d, input logic ack);
        bit_en    = en;
        sync      = s;
        serial_in = d;
        rd_ack    = ack;
        @(posedge clk);
        #1;
        bit_en    = 1'b0;
        sync      = 1'b0;
        serial_in = 1'b0;
        rd_ack    = 1'b0;
    endtask

    // Full LSB-first frame on consecutive edges, optional ack on the last edge.
    task automatic send_word(input logic [5:0] w, input logic ack_last);
        for (int k = 0; k < 6; k++) cyc(1'b1, k == 0, w[k], ack_last && (k == 5));
    endtask

    task automatic pulse_clear();
        #2 clear = 1'b1;
        #1;
        check("clr_data",  data_out,  6'h00);
        check("clr_valid", valid,     1'b0);
        check("clr_ovr",   overrun,   1'b0);
        check("clr_ferr",  frame_err, 1'b0);
        check("clr_busy",  busy,      1'b0);
        #1 clear = 1'b0;
    endtask

    initial begin
        logic [5:0] w;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",  data_out,  6'h00);
        check("rst_valid", valid,     1'b0);
        check("rst_ovr",   overrun,   1'b0);
        check("rst_ferr",  frame_err, 1'b0);
        check("rst_busy",  busy,      1'b0);
        clear = 1'b0;

        // LSB-first 6'h2D, busy on edges 1-5
        w = 6'h2D;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, k == 0, w[k], 1'b0);
            if (k < 5) begin
                check("lsb_busy",  busy,  1'b1);
                check("lsb_vld0",  valid, 1'b0);
            end
        end
        check("lsb_data",  data_out, 6'h2D);
        check("lsb_valid", valid,    1'b1);
        check("lsb_busy0", busy,     1'b0);
        check("msb_2d",    data_m,   6'h2D);

        // Ack clears valid, data held
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_valid", valid,    1'b0);
        check("ack_data",  data_out, 6'h2D);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_idle",  valid,    1'b0);

        // Intermediate word so the stalled frame shows a change
        send_word(6'h15, 1'b0);
        check("w15_data", data_out, 6'h15);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Stall 3 cycles after bit 2
        w = 6'h2D;
        for (int k = 0; k < 3; k++) cyc(1'b1, k == 0, w[k], 1'b0);
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            check("stall_busy", busy,     1'b1);
            check("stall_data", data_out, 6'h15);
            check("stall_vld",  valid,    1'b0);
        end
        for (int k = 3; k < 6; k++) cyc(1'b1, 1'b0, w[k], 1'b0);
        check("stall_done", data_out, 6'h2D);
        check("stall_vld1", valid,    1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_ack",  valid,    1'b0);
        check("stall_hold", data_out, 6'h2D);

        // Overrun: back-to-back frames, no ack
        send_word(6'h2D, 1'b0);
        check("ovr_first",  overrun,  1'b0);
        send_word(6'h15, 1'b0);
        check("ovr_data",   data_out, 6'h15);
        check("ovr_valid",  valid,    1'b1);
        check("ovr_flag",   overrun,  1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_sticky", overrun,  1'b1);
        pulse_clear();

        // Same pair with ack on the second completion edge
        send_word(6'h2D, 1'b0);
        send_word(6'h15, 1'b1);
        check("ack_ovr_data",  data_out, 6'h15);
        check("ack_ovr_valid", valid,    1'b1);
        check("ack_ovr_flag",  overrun,  1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Premature sync after 3 bits, then 6'h3F
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_ferr0", frame_err, 1'b0);
        w = 6'h3F;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, k == 0, w[k], 1'b0);
            if (k == 0) check("pre_ferr1", frame_err, 1'b1);
            if (k == 1) check("pre_ferr2", frame_err, 1'b0);
        end
        check("pre_data",  data_out, 6'h3F);
        check("pre_valid", valid,    1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort with ones pending, then 6'h01: no stale bits survive
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, 1'b1, 1'b0);
        send_word(6'h01, 1'b0);
        check("stale_data", data_out, 6'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Async clear mid-frame after 4 bits
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, 1'b1, 1'b0);
        check("mid_busy", busy, 1'b1);
        pulse_clear();
        send_word(6'h01, 1'b0);
        check("post_data",  data_out, 6'h01);
        check("post_valid", valid,    1'b1);
        check("msb_data",   data_m,   6'h20);
        check("msb_valid",  valid_m,  1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Non-sync bits in IDLE are ignored
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("idle_busy",  busy,     1'b0);
        check("idle_valid", valid,    1'b0);
        check("idle_mbusy", busy_m,   1'b0);
        check("idle_mvld",  valid_m,  1'b0);
        check("idle_data",  data_out, 6'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
